// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed cascade of direct-form II biquads sharing one MAC datapath.
// Define IIR_SATURATE_EN to clamp every reduction to WIDTH; otherwise results wrap.
module iir_biquad_cascade #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 10,
    parameter int SECTIONS = 2,
    localparam int NCOEF   = 5 * SECTIONS,
    localparam int AW      = $clog2(NCOEF)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    input  logic                    clear,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [WIDTH-1:0] coef_wdata,
    output logic                    coef_err
);

    localparam int SW   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int SUMW = WIDTH + 3;
    localparam logic signed [WIDTH-1:0] COEF_ONE = WIDTH'(1 << FRAC);

    typedef enum logic [1:0] {IDLE, CALC_W, CALC_Y} state_t;

    state_t                  state, state_nxt;
    logic [SW-1:0]           sec;
    logic signed [WIDTH-1:0] coef [NCOEF];
    logic signed [WIDTH-1:0] d1 [SECTIONS];
    logic signed [WIDTH-1:0] d2 [SECTIONS];
    logic signed [WIDTH-1:0] x_p0, w_p1;
    logic signed [WIDTH-1:0] c_b0, c_b1, c_b2, c_a1, c_a2, s_d1, s_d2;
    logic signed [SUMW-1:0]  w_sum, y_sum;
    logic signed [WIDTH-1:0] w_red, y_red;
    logic                    last_sec, addr_ok;

`ifdef IIR_SATURATE_EN
    localparam logic signed [SUMW-1:0] SAT_MAX = {4'b0000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SUMW-1:0] SAT_MIN = {4'b1111, {(WIDTH-1){1'b0}}};
`endif

    // Full-precision product, floored by FRAC, kept at sum width
    function automatic logic signed [SUMW-1:0] mul_shift(input logic signed [WIDTH-1:0] a,
                                                          input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        p = p >>> FRAC;
        return p[SUMW-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [SUMW-1:0] v);
`ifdef IIR_SATURATE_EN
        if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        else                  return v[WIDTH-1:0];
`else
        return v[WIDTH-1:0];
`endif
    endfunction

    assign in_ready = (state == IDLE);
    assign last_sec = (sec == SW'(SECTIONS - 1));
    assign addr_ok  = (coef_addr < AW'(NCOEF));

    always_comb begin
        c_b0 = '0; c_b1 = '0; c_b2 = '0; c_a1 = '0; c_a2 = '0;
        s_d1 = '0; s_d2 = '0;
        for (int i = 0; i < SECTIONS; i++) begin
            if (sec == SW'(i)) begin
                c_b0 = coef[5*i];
                c_b1 = coef[5*i+1];
                c_b2 = coef[5*i+2];
                c_a1 = coef[5*i+3];
                c_a2 = coef[5*i+4];
                s_d1 = d1[i];
                s_d2 = d2[i];
            end
        end
    end

    // p0 -> p1: feedback half of the section
    assign w_sum = SUMW'(x_p0) - mul_shift(c_a1, s_d1) - mul_shift(c_a2, s_d2);
    assign w_red = reduce(w_sum);

    // p1 -> output / next section: feed-forward half
    assign y_sum = mul_shift(c_b0, w_p1) + mul_shift(c_b1, s_d1) + mul_shift(c_b2, s_d2);
    assign y_red = reduce(y_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!clear && in_valid) state_nxt = CALC_W;
            CALC_W:  state_nxt = clear ? IDLE : CALC_Y;
            CALC_Y:  state_nxt = (clear || last_sec) ? IDLE : CALC_W;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec       <= '0;
            x_p0      <= '0;
            w_p1      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
            for (int i = 0; i < NCOEF; i++)
                coef[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
            for (int i = 0; i < SECTIONS; i++) begin
                d1[i] <= '0;
                d2[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            coef_err  <= 1'b0;
            if (coef_we) begin
                if (state == IDLE && addr_ok) begin
                    for (int i = 0; i < NCOEF; i++)
                        if (coef_addr == AW'(i)) coef[i] <= coef_wdata;
                end else begin
                    coef_err <= 1'b1;
                end
            end
            if (clear) begin
                for (int i = 0; i < SECTIONS; i++) begin
                    d1[i] <= '0;
                    d2[i] <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            x_p0 <= in_data;
                            sec  <= '0;
                        end
                    end
                    CALC_W: w_p1 <= w_red;
                    CALC_Y: begin
                        for (int i = 0; i < SECTIONS; i++) begin
                            if (sec == SW'(i)) begin
                                d2[i] <= d1[i];
                                d1[i] <= w_p1;
                            end
                        end
                        if (last_sec) begin
                            out_data  <= y_red;
                            out_valid <= 1'b1;
                        end else begin
                            x_p0 <= y_red;
                            sec  <= sec + SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
